// File: rtl/udiv_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// FIX state exists only when UDIV_SIGNED_EN is defined.
package udiv_pkg;

`ifdef UDIV_SIGNED_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
`endif

  function automatic int unsigned iter_count(input int unsigned aw, input int unsigned bpc);
    return aw / bpc;
  endfunction

  // Width holding 0..ITER inclusive.
  function automatic int unsigned cnt_width(input int unsigned aw, input int unsigned bpc);
    return $clog2((aw / bpc) + 1);
  endfunction

endpackage

// File: rtl/udiv_seq_if.sv
// Operand/result handshake bundle for udiv_seq.
// is_signed is present only when UDIV_SIGNED_EN is defined.
interface udiv_seq_if #(
  parameter int AW = 18,
  parameter int BW = 10
) ();
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] quo;
  logic [BW-1:0] res;
  logic          divide_by_0;
`ifdef UDIV_SIGNED_EN
  logic          is_signed;

  modport master (
    output in_valid, a, b, out_ready, is_signed,
    input  in_ready, out_valid, quo, res, divide_by_0
  );

  modport slave (
    input  in_valid, a, b, out_ready, is_signed,
    output in_ready, out_valid, quo, res, divide_by_0
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quo, res, divide_by_0
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quo, res, divide_by_0
  );
`endif
endinterface

// File: rtl/udiv_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor over BW+1 bits, keep the difference if non-negative.
module udiv_step #(
  parameter int BW = 10
) (
  input  logic [BW-1:0] pr_in,
  input  logic          bit_in,
  input  logic [BW-1:0] d,
  output logic [BW-1:0] pr_out,
  output logic          q_bit
);
  logic [BW:0] shifted_s;
  logic [BW:0] trial_s;

  assign shifted_s = {pr_in, bit_in};
  assign trial_s   = shifted_s - {1'b0, d};

  // Select restored or reduced remainder from the trial borrow.
  always_comb begin
    q_bit  = ~trial_s[BW];
    pr_out = shifted_s[BW-1:0];
    if (q_bit) begin
      pr_out = trial_s[BW-1:0];
    end else begin
      pr_out = shifted_s[BW-1:0];
    end
  end
endmodule

// File: rtl/udiv_seq.sv
// Multi-cycle restoring divider, BPC quotient bits per clock, valid/ready on both sides.
// Define UDIV_SIGNED_EN to add two's-complement operation with a sign fix-up cycle.
module udiv_seq
  import udiv_pkg::*;
#(
  parameter int AW  = 18,
  parameter int BW  = 10,
  parameter int BPC = 1
) (
  input logic     clk,
  input logic     rst_n,
  udiv_seq_if.slave bus
);
  localparam int ITER  = iter_count(AW, BPC);
  localparam int CNT_W = cnt_width(AW, BPC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);
  localparam logic [AW-1:0]    A_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0]    A_ONES   = {AW{1'b1}};
  localparam logic [BW-1:0]    B_ZERO   = {BW{1'b0}};
  localparam logic [BW-1:0]    B_ONE    = BW'(1'b1);

  state_t         state_r;
  state_t         state_next_s;
  state_t         finish_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [BW-1:0]  pr_r;
  logic [AW-1:0]  sh_r;
  logic [BW-1:0]  b_r;
  logic [AW-1:0]  quo_r;
  logic [BW-1:0]  res_r;
  logic           div0_r;
  logic           out_valid_r;
  logic           in_ready_r;

  logic           accept_s;
  logic           b_zero_s;
  logic           b_one_s;
  logic [AW-1:0]  a_mag_s;
  logic [BW-1:0]  b_mag_s;
  logic [BW-1:0]  pr_src_s;
  logic [AW-1:0]  sh_src_s;
  logic [BW-1:0]  d_src_s;
  logic [BW-1:0]  pr_chain_s [0:BPC];
  logic [BPC-1:0] q_chain_s;
  logic [AW-1:0]  sh_next_s;

  assign accept_s = bus.in_valid & in_ready_r;
  assign b_zero_s = (bus.b == B_ZERO);
  assign b_one_s  = (bus.b == B_ONE);

`ifdef UDIV_SIGNED_EN
  localparam logic [AW-1:0] A_ONE = AW'(1'b1);
  logic sgn_r;
  logic neg_q_r;
  logic neg_r_r;
  logic a_neg_s;
  logic b_neg_s;

  assign a_neg_s = bus.is_signed & bus.a[AW-1];
  assign b_neg_s = bus.is_signed & bus.b[BW-1];
  assign a_mag_s = a_neg_s ? (~bus.a + A_ONE) : bus.a;
  assign b_mag_s = b_neg_s ? (~bus.b + B_ONE) : bus.b;
`else
  assign a_mag_s = bus.a;
  assign b_mag_s = bus.b;
`endif

  // The accept edge already resolves the first BPC bits straight from the operands.
  always_comb begin
    if (state_r == IDLE) begin
      pr_src_s = B_ZERO;
      sh_src_s = a_mag_s;
      d_src_s  = b_mag_s;
    end else begin
      pr_src_s = pr_r;
      sh_src_s = sh_r;
      d_src_s  = b_r;
    end
  end

  assign pr_chain_s[0] = pr_src_s;

  for (genvar k = 0; k < BPC; k++) begin : g_step
    udiv_step #(.BW(BW)) u_step (
      .pr_in  (pr_chain_s[k]),
      .bit_in (sh_src_s[AW-1-k]),
      .d      (d_src_s),
      .pr_out (pr_chain_s[k+1]),
      .q_bit  (q_chain_s[BPC-1-k])
    );
  end

  assign sh_next_s = (sh_src_s << BPC) | AW'(q_chain_s);

  // Where a finished calculation goes: straight to DONE, or through the sign fix-up.
  always_comb begin
    finish_state_s = DONE;
`ifdef UDIV_SIGNED_EN
    if (state_r == IDLE) begin
      finish_state_s = bus.is_signed ? FIX : DONE;
    end else begin
      finish_state_s = sgn_r ? FIX : DONE;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_next_s = IDLE;
        end else if (b_zero_s || b_one_s) begin
          state_next_s = DONE;
        end else if (ITER == 1) begin
          state_next_s = finish_state_s;
        end else begin
          state_next_s = CALC;
        end
      end
      CALC: begin
        if (cnt_r == CNT_ONE) begin
          state_next_s = finish_state_s;
        end else begin
          state_next_s = CALC;
        end
      end
`ifdef UDIV_SIGNED_EN
      FIX:  state_next_s = DONE;
`endif
      DONE: begin
        if (bus.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register with registered handshake flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == DONE);
      in_ready_r  <= (state_next_s == IDLE);
    end
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      pr_r   <= B_ZERO;
      sh_r   <= A_ZERO;
      b_r    <= B_ZERO;
      quo_r  <= A_ZERO;
      res_r  <= B_ZERO;
      div0_r <= 1'b0;
`ifdef UDIV_SIGNED_EN
      sgn_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            b_r <= b_mag_s;
`ifdef UDIV_SIGNED_EN
            sgn_r   <= bus.is_signed;
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
`endif
            if (b_zero_s) begin
              quo_r  <= A_ONES;
              res_r  <= B_ZERO;
              div0_r <= 1'b1;
            end else if (b_one_s) begin
              quo_r  <= bus.a;
              res_r  <= B_ZERO;
              div0_r <= 1'b0;
            end else begin
              pr_r  <= pr_chain_s[BPC];
              sh_r  <= sh_next_s;
              cnt_r <= CNT_LOAD;
              if (state_next_s == DONE) begin
                quo_r  <= sh_next_s;
                res_r  <= pr_chain_s[BPC];
                div0_r <= 1'b0;
              end
            end
          end
        end
        CALC: begin
          pr_r  <= pr_chain_s[BPC];
          sh_r  <= sh_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (state_next_s == DONE) begin
            quo_r  <= sh_next_s;
            res_r  <= pr_chain_s[BPC];
            div0_r <= 1'b0;
          end
        end
`ifdef UDIV_SIGNED_EN
        // Truncating division: quotient negative on sign mismatch, remainder follows dividend.
        FIX: begin
          quo_r  <= neg_q_r ? (~sh_r + A_ONE) : sh_r;
          res_r  <= neg_r_r ? (~pr_r + B_ONE) : pr_r;
          div0_r <= 1'b0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quo         = quo_r;
  assign bus.res         = res_r;
  assign bus.divide_by_0 = div0_r;

endmodule

// File: tb/tb_udiv_seq.sv
// Directed bench for udiv_seq: BPC=1 instance for most cases, BPC=3 instance for latency scaling.
module tb_udiv_seq;
  localparam int AW = 18;
  localparam int BW = 10;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   lat;

  udiv_seq_if #(.AW(AW), .BW(BW)) if1 ();
  udiv_seq_if #(.AW(AW), .BW(BW)) if3 ();

  udiv_seq #(.AW(AW), .BW(BW), .BPC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  udiv_seq #(.AW(AW), .BW(BW), .BPC(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation on the BPC=1 instance, optionally stall the result, then drain it.
  task automatic do_op(input string tag, input logic [AW-1:0] av, input logic [BW-1:0] bv,
                       input logic [AW-1:0] eq, input logic [BW-1:0] er, input logic ed,
                       input int el, input int hold);
    chk({tag, ".in_ready"}, 32'(if1.in_ready), 32'd1);
    if1.a = av;
    if1.b = bv;
    if1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
    lat = 1;
    while (!if1.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(el));
    chk({tag, ".quo"}, 32'(if1.quo), 32'(eq));
    chk({tag, ".res"}, 32'(if1.res), 32'(er));
    chk({tag, ".div0"}, 32'(if1.divide_by_0), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      if1.in_valid = 1'b1;
      if1.a = 18'd999;
      if1.b = 10'd0;
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, 32'(if1.out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(if1.in_ready), 32'd0);
      chk({tag, ".hold_quo"}, 32'(if1.quo), 32'(eq));
      chk({tag, ".hold_res"}, 32'(if1.res), 32'(er));
    end
    if1.in_valid = 1'b0;
    if1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if1.out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(if1.out_valid), 32'd0);
    chk({tag, ".ready_rise"}, 32'(if1.in_ready), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    if1.in_valid = 1'b0;
    if1.a = 18'd0;
    if1.b = 10'd0;
    if1.out_ready = 1'b0;
    if3.in_valid = 1'b0;
    if3.a = 18'd0;
    if3.b = 10'd0;
    if3.out_ready = 1'b1;
`ifdef UDIV_SIGNED_EN
    if1.is_signed = 1'b0;
    if3.is_signed = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(if1.out_valid), 32'd0);
    chk("reset.in_ready", 32'(if1.in_ready), 32'd1);
    chk("reset.quo", 32'(if1.quo), 32'd0);
    chk("reset.res", 32'(if1.res), 32'd0);
    chk("reset.div0", 32'(if1.divide_by_0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("norm",   18'd100000, 10'd7,    18'd14285,  10'd5,   1'b0, 18, 0);
    do_op("max",    18'd262143, 10'd1023, 18'd256,    10'd255, 1'b0, 18, 0);
    do_op("div0",   18'd5,      10'd0,    18'h3FFFF,  10'd0,   1'b1, 1,  0);
    do_op("one",    18'd77,     10'd1,    18'd77,     10'd0,   1'b0, 1,  0);
    do_op("small",  18'd17,     10'd1023, 18'd0,      10'd17,  1'b0, 18, 0);
    do_op("half",   18'd262143, 10'd2,    18'd131071, 10'd1,   1'b0, 18, 0);
    do_op("equal",  18'd1023,   10'd1023, 18'd1,      10'd0,   1'b0, 18, 0);
    do_op("bpress", 18'd12345,  10'd100,  18'd123,    10'd45,  1'b0, 18, 5);
    do_op("after",  18'd40000,  10'd13,   18'd3076,   10'd12,  1'b0, 18, 0);

    // BPC=3 resolves three bits per clock.
    if3.a = 18'd262143;
    if3.b = 10'd1023;
    if3.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if3.in_valid = 1'b0;
    lat = 1;
    while (!if3.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bpc3.latency", 32'(lat), 32'd6);
    chk("bpc3.quo", 32'(if3.quo), 32'd256);
    chk("bpc3.res", 32'(if3.res), 32'd255);
    @(posedge clk);
    #1;

    // Abort mid-calculation with an asynchronous reset.
    if1.a = 18'd50000;
    if1.b = 10'd9;
    if1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 32'(if1.out_valid), 32'd0);
    chk("abort.in_ready", 32'(if1.in_ready), 32'd1);
    chk("abort.quo", 32'(if1.quo), 32'd0);
    chk("abort.res", 32'(if1.res), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("post_rst", 18'd1000, 10'd3, 18'd333, 10'd1, 1'b0, 18, 0);

    for (int n = 0; n < 30; n++) begin
      ra = 18'($urandom_range(0, 262143));
      rb = 10'($urandom_range(1, 1023));
      do_op("rand", ra, rb, ra / 18'(rb), 10'(ra % 18'(rb)), 1'b0, (rb == 10'd1) ? 1 : 18, 0);
    end

`ifdef UDIV_SIGNED_EN
    if1.is_signed = 1'b1;
    do_op("signed", 18'h3FF9C, 10'd7, 18'h3FFF2, 10'h3FE, 1'b0, 19, 0);
    if1.is_signed = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/udiv_seq.md
Name: udiv_seq

Overview:
- Multi-cycle unsigned integer divider: AW-bit dividend by BW-bit divisor, giving AW-bit quotient and BW-bit remainder.
- Restoring algorithm, BPC quotient bits per clock, with valid/ready handshakes on input and output.
- Successor to the combinational divider: sits between pipeline stages of the datapath where a full-width combinational divide cannot meet timing.
- Adds divisor fast paths, backpressure, and optional signed mode.

Parameters:
- AW, 18, dividend/quotient width (AW >= 2).
- BW, 10, divisor/remainder width (BW >= 2).
- BPC, 1, quotient bits resolved per clock; AW % BPC must be 0.
- Derived local constant ITER = AW/BPC, the number of calculation cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept operands.
- a  in  AW  dividend.
- b  in  BW  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quo  out  AW  quotient.
- res  out  BW  remainder.
- divide_by_0  out  1  result came from b == 0.

Behaviour:
- One clock domain; reset is asynchronous and active-low (rst_n).
- Reset forces state IDLE and clears quo, res, divide_by_0, out_valid and the internal shift/remainder registers to 0. in_ready is 1 after reset.
- A reset mid-calculation aborts the operation; no result is produced.
- States:
  - IDLE: in_ready = 1.
  - CALC: in_ready = 0, out_valid = 0.
  - DONE: out_valid = 1, in_ready = 0.
- Accept: in_valid & in_ready at a rising edge latches a and b.
- IDLE transitions on accept:
  - b == 0: go to DONE; quo = all ones, res = 0, divide_by_0 = 1.
  - b == 1: go to DONE; quo = a, res = 0, divide_by_0 = 0.
  - Otherwise: go to CALC; iteration counter = ITER, partial remainder (BW+1 bits) = 0, shift register = a.
- CALC, each cycle, BPC chained restoring steps, MSB first:
  - Partial remainder pr = {pr[BW-1:0], next dividend bit}; trial t = pr - {1'b0, b}.
  - If t[BW] == 0: pr = t and the quotient bit is 1; else pr is kept and the quotient bit is 0.
  - Quotient bits shift into the vacated LSBs of the shift register.
  - Counter decrements; after the ITER-th calculation cycle, go to DONE with quo = shift register, res = pr[BW-1:0], divide_by_0 = 0.
- Latency, accept edge to out_valid high:
  - Normal divide: ITER cycles.
  - Fast paths: 1 cycle.
- DONE: quo, res and divide_by_0 are held stable while out_ready = 0. On out_valid & out_ready, go to IDLE; out_valid drops next cycle.
- Throughput: no overlap between operations; the next accept is possible at earliest the cycle after output handshake.
- in_valid with in_ready = 0 is ignored; a and b are sampled only at accept.
- Invariant: quo*b + res == a and res < b whenever b != 0.

Optional Feature:
- Macro: UDIV_SIGNED_EN.
- When defined:
  - Adds input port is_signed (1 bit), sampled at accept.
  - If is_signed = 1, a and b are two's complement. Magnitudes are divided by the same datapath; quo is negated if the signs differ and res takes the dividend's sign (truncating division).
  - Sign fix-up takes one extra cycle before DONE, so latency is ITER+1; fast paths stay at 1.
  - b == 0 still gives quo all ones, res = 0, divide_by_0 = 1.
  - min/-1 gives quo = 2^(AW-1) bit pattern (wraps) with res = 0.
  - b == 1 fast path applies only for +1.
- When undefined: no is_signed port, pure unsigned, latency as above.

Decomposition:
- Package udiv_pkg holds:
  - State encodings IDLE/CALC/DONE (plus FIX under UDIV_SIGNED_EN).
  - A function computing ITER and the counter width, clog2(ITER+1).
- One natural sub-module, udiv_step: combinational single restoring step (BW+1-bit trial subtract and select), instantiated BPC times in a chain inside the CALC datapath.

Test Plan:
- Normal divide: AW=18, BW=10, BPC=1; a=100000, b=7 -> quo=14285, res=5, divide_by_0=0; out_valid exactly 18 cycles after accept.
- Maximum operands: a=262143, b=1023 -> quo=256, res=255. Repeat with BPC=3 -> same result, latency 6.
- Divide by zero: a=5, b=0 -> quo=0x3FFFF, res=0, divide_by_0=1, out_valid 1 cycle after accept. Then a=77, b=1 -> quo=77, res=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> quo/res stable, in_ready=0, in_valid pulses ignored. Release -> out_valid falls next cycle and in_ready rises.
- Reset mid-operation: assert rst_n=0 at CALC cycle 9 -> outputs 0 immediately, IDLE. Next op a=1000, b=3 -> quo=333, res=1.
- Signed mode (UDIV_SIGNED_EN): is_signed=1, a=-100, b=7 -> quo=-14, res=-2, latency 19. Random 10k unsigned vectors check quo*b+res==a, res<b.
